// File: rtl/spi_apb_ctrl.sv
// -----------------------------------------------------------------------------
// spi_apb_ctrl
// APB3 slave that feeds a CPOL=0/CPHA=0 byte-wide SPI master driver.
// Software pushes bytes into a TX FIFO; a sequencer issues one driver
// transaction per byte and stores the received byte in an RX FIFO that
// software pops.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   apb_*               APB3 slave interface (zero wait states)
//   irq_o               level interrupt (registered)
//   spi_start_o         one-cycle start pulse to the driver
//   spi_data_bo         byte for the driver to transmit
//   spi_busy_i          driver busy
//   spi_data_bi         byte received by the driver in its last transaction
// -----------------------------------------------------------------------------
module spi_apb_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic        apb_pwrite_i,
    input  logic [3:0]  apb_paddr_bi,
    input  logic [31:0] apb_pwdata_bi,
    output logic [31:0] apb_prdata_bo,
    output logic        apb_pready_o,
    output logic        apb_pslverr_o,
    output logic        irq_o,
    output logic        spi_start_o,
    output logic [7:0]  spi_data_bo,
    input  logic        spi_busy_i,
    input  logic [7:0]  spi_data_bi
);

    localparam int unsigned      PTR_W   = CNT_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_TXDATA = 2'd2;
    localparam logic [1:0] A_RXDATA = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    // APB decode: side effects only in the access phase
    logic       apb_acc;
    logic       apb_wr;
    logic       apb_rd;
    logic [1:0] reg_sel;

    assign apb_acc      = apb_psel_i & apb_penable_i;
    assign apb_wr       = apb_acc & apb_pwrite_i;
    assign apb_rd       = apb_acc & ~apb_pwrite_i;
    assign reg_sel      = apb_paddr_bi[3:2];
    assign apb_pready_o = 1'b1;

    // Low address bits and upper write data are don't-care
    logic unused_ok;
    assign unused_ok = ^{apb_paddr_bi[1:0], apb_pwdata_bi[31:8]};

    // CTRL register and self-clearing flush strobes
    logic en_q, en_d;
    logic irq_en_q, irq_en_d;
    logic tx_flush, rx_flush;

    assign tx_flush = apb_wr & (reg_sel == A_CTRL) & apb_pwdata_bi[1];
    assign rx_flush = apb_wr & (reg_sel == A_CTRL) & apb_pwdata_bi[2];

    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (apb_wr && (reg_sel == A_CTRL)) begin
            en_d     = apb_pwdata_bi[0];
            irq_en_d = apb_pwdata_bi[3];
        end
    end

    // TX FIFO
    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt_q == DEPTH_C);
    assign tx_empty = (tx_cnt_q == '0);
    // Full check uses the pre-pop count, so a push to a full FIFO is dropped
    assign tx_push  = apb_wr & (reg_sel == A_TXDATA) & ~tx_full & ~tx_flush;

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_cnt_d  = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + PTR_W'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_W'(1);
            tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= apb_pwdata_bi[7:0];
    end

    // RX FIFO
    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full  = (rx_cnt_q == DEPTH_C);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_pop   = apb_rd & (reg_sel == A_RXDATA) & ~rx_empty & ~rx_flush;

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_cnt_d  = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + PTR_W'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_W'(1);
            rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= spi_data_bi;
    end

    // Sequencer: one driver transaction in flight at a time
    state_e     state_q, state_d;
    logic       can_start;
    logic       spi_start_d;
    logic [7:0] spi_data_d;
    logic       irq_d;

    // A full RX stalls new starts, so RX can never overflow
    assign can_start = en_q & ~tx_empty & (rx_cnt_q != DEPTH_C);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (can_start)   state_d = ST_START;
            ST_START:                      state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (spi_busy_i)  state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!spi_busy_i) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        spi_start_d = 1'b0;
        spi_data_d  = spi_data_bo;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_start) begin
                    spi_start_d = 1'b1;
                    spi_data_d  = tx_mem_q[tx_rptr_q];
                    tx_pop      = 1'b1;
                end
            end
            ST_WAIT_DONE: rx_push = ~spi_busy_i;
            default: ;
        endcase
    end

    assign irq_d = irq_en_q & (~rx_empty | (en_q & tx_empty & (state_q == ST_IDLE)));

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_cnt_q    <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_cnt_q    <= '0;
            spi_start_o <= 1'b0;
            spi_data_bo <= 8'd0;
            irq_o       <= 1'b0;
        end else begin
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_cnt_q    <= rx_cnt_d;
            spi_start_o <= spi_start_d;
            spi_data_bo <= spi_data_d;
            irq_o       <= irq_d;
        end
    end

    // Read data / error response, combinational during access only
    always_comb begin
        apb_prdata_bo = 32'd0;
        apb_pslverr_o = 1'b0;
        if (apb_rd) begin
            case (reg_sel)
                A_CTRL:   apb_prdata_bo = {28'd0, irq_en_q, 2'b00, en_q};
                A_STATUS: apb_prdata_bo = {16'd0, 4'(rx_cnt_q), 4'(tx_cnt_q), 3'd0,
                                           rx_empty, rx_full, tx_empty, tx_full,
                                           state_q != ST_IDLE};
                A_TXDATA: apb_prdata_bo = 32'd0;
                A_RXDATA: begin
                    if (rx_empty) apb_pslverr_o = 1'b1;
                    else          apb_prdata_bo = {24'd0, rx_mem_q[rx_rptr_q]};
                end
                default:  apb_prdata_bo = 32'd0;
            endcase
        end else if (apb_wr && (reg_sel == A_TXDATA) && tx_full) begin
            apb_pslverr_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_apb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_apb_ctrl
// Self-checking bench for spi_apb_ctrl: a directed vector table, hand-written
// corner-case sequences and a randomized phase, all checked every cycle
// against a queue-based transaction model.
// -----------------------------------------------------------------------------
module tb_spi_apb_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel = 1'b0, pen = 1'b0, pwrite = 1'b0;
    logic [3:0]  paddr = 4'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready, pslverr, irq, spi_start;
    logic [7:0]  spi_dout;
    logic [7:0]  spi_din = 8'd0;
    logic        spi_busy;
    logic        drv_busy = 1'b0;
    logic        force_busy = 1'b0;

    assign spi_busy = drv_busy | force_busy;

    always #5 clk = ~clk;

    spi_apb_ctrl #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .apb_psel_i    (psel),
        .apb_penable_i (pen),
        .apb_pwrite_i  (pwrite),
        .apb_paddr_bi  (paddr),
        .apb_pwdata_bi (pwdata),
        .apb_prdata_bo (prdata),
        .apb_pready_o  (pready),
        .apb_pslverr_o (pslverr),
        .irq_o         (irq),
        .spi_start_o   (spi_start),
        .spi_data_bo   (spi_dout),
        .spi_busy_i    (spi_busy),
        .spi_data_bi   (spi_din)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: FIFO contents as queues, transaction progress as a phase
    // (0 none, 1 started awaiting busy, 2 busy seen awaiting its fall)
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_en = 1'b0, m_irq_en = 1'b0, m_start = 1'b0, m_irq = 1'b0;
    logic [7:0] m_data = 8'd0;
    int         phase = 0;

    // Driver model state
    logic       drv_pending = 1'b0;
    int         drv_wait = 0;
    int         drv_left = 0;
    logic       fixed_slave = 1'b0;
    logic [7:0] next_slave = 8'd0;
    logic [7:0] seen_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = (phase != 0);
        s[1]     = (tx_q.size() == DEPTH);
        s[2]     = (tx_q.size() == 0);
        s[3]     = (rx_q.size() == DEPTH);
        s[4]     = (rx_q.size() == 0);
        s[11:8]  = 4'(tx_q.size());
        s[15:12] = 4'(rx_q.size());
        return s;
    endfunction

    task automatic model_comb(input logic acc, input logic wr, input logic [3:0] addr,
                              output logic [31:0] rd, output logic err);
        rd  = 32'd0;
        err = 1'b0;
        if (acc && !wr) begin
            case (addr[3:2])
                2'd0: rd = {28'd0, m_irq_en, 2'b00, m_en};
                2'd1: rd = status_exp();
                2'd2: rd = 32'd0;
                default: begin
                    if (rx_q.size() == 0) err = 1'b1;
                    else                  rd  = {24'd0, rx_q[0]};
                end
            endcase
        end else if (acc && wr && addr[3:2] == 2'd2 && tx_q.size() == DEPTH) begin
            err = 1'b1;
        end
    endtask

    task automatic model_edge(input logic r, input logic acc, input logic wr,
                              input logic [3:0] addr, input logic [31:0] wd);
        logic [1:0] a;
        logic txf, rxf, rd_pop, rx_push, tx_full_pre, irq_n, st;
        if (r) begin
            tx_q.delete(); rx_q.delete();
            m_en = 1'b0; m_irq_en = 1'b0; m_start = 1'b0; m_data = 8'd0; m_irq = 1'b0;
            phase = 0;
            return;
        end
        a           = addr[3:2];
        txf         = acc && wr && a == 2'd0 && wd[1];
        rxf         = acc && wr && a == 2'd0 && wd[2];
        irq_n       = m_irq_en && (rx_q.size() != 0 || (m_en && tx_q.size() == 0 && phase == 0));
        tx_full_pre = (tx_q.size() == DEPTH);
        rd_pop      = acc && !wr && a == 2'd3 && rx_q.size() != 0;
        rx_push     = (phase == 2) && !spi_busy;
        st          = 1'b0;
        if (phase == 0) begin
            if (m_en && tx_q.size() != 0 && rx_q.size() != DEPTH) begin
                st     = 1'b1;
                m_data = tx_q.pop_front();
                phase  = 1;
            end
        end else if (phase == 1) begin
            if (spi_busy) phase = 2;
        end else if (rx_push) begin
            phase = 0;
        end
        if (rd_pop)  void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(spi_din);
        if (rxf)     rx_q.delete();
        if (acc && wr && a == 2'd2 && !tx_full_pre && !txf) tx_q.push_back(wd[7:0]);
        if (txf)     tx_q.delete();
        if (acc && wr && a == 2'd0) begin
            m_en     = wd[0];
            m_irq_en = wd[3];
        end
        m_start = st;
        m_irq   = irq_n;
    endtask

    // Driver: busy rises 1..3 cycles after the start pulse, stays 1..4 cycles
    task automatic drv_update();
        if (drv_busy) begin
            if (drv_left <= 1) drv_busy = 1'b0;
            else               drv_left--;
        end else if (drv_pending) begin
            if (drv_wait == 0) begin
                drv_pending = 1'b0;
                drv_busy    = 1'b1;
                drv_left    = int'($urandom_range(1, 4));
                spi_din     = fixed_slave ? next_slave : 8'($urandom);
            end else begin
                drv_wait--;
            end
        end
        if (spi_start === 1'b1) begin
            drv_pending = 1'b1;
            drv_wait    = int'($urandom_range(0, 2));
        end
    endtask

    // One clock: drive at the falling edge, check combinational APB response,
    // advance the model at the rising edge, check registered outputs after it
    task automatic step(input logic r, input logic sel, input logic en, input logic wr,
                        input logic [3:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic err_o);
        logic [31:0] e_rd;
        logic        e_err;
        drv_update();
        rst = r; psel = sel; pen = en; pwrite = wr; paddr = addr; pwdata = wd;
        #1;
        model_comb(sel & en, wr, addr, e_rd, e_err);
        rd_o  = prdata;
        err_o = pslverr;
        chk("prdata", prdata, e_rd);
        chk("pslverr", {31'd0, pslverr}, {31'd0, e_err});
        chk("pready", {31'd0, pready}, 32'd1);
        @(posedge clk);
        model_edge(r, sel & en, wr, addr, wd);
        if (r) begin
            drv_pending = 1'b0;
            drv_busy    = 1'b0;
        end
        @(negedge clk);
        chk("spi_start", {31'd0, spi_start}, {31'd0, m_start});
        chk("spi_data", {24'd0, spi_dout}, {24'd0, m_data});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        if (spi_start === 1'b1) seen_q.push_back(spi_dout);
    endtask

    task automatic idle(input int n);
        logic [31:0] d;
        logic        e;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, d, e);
    endtask

    task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        logic [31:0] d;
        logic        e;
        step(1'b0, 1'b1, 1'b0, wr, addr, wd, d, e);
        step(1'b0, 1'b1, 1'b1, wr, addr, wd, rd, err);
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wd;
        int          idle_n;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] r;

        tbl[0] = '{1'b1, 4'h8, 32'h0000_00A5, 4,  32'h0000_0000, 1'b0};
        tbl[1] = '{1'b0, 4'h4, 32'h0,         0,  32'h0000_0110, 1'b0};
        tbl[2] = '{1'b1, 4'h0, 32'h0000_0001, 20, 32'h0000_0000, 1'b0};
        tbl[3] = '{1'b0, 4'h4, 32'h0,         0,  32'h0000_1004, 1'b0};
        tbl[4] = '{1'b0, 4'hC, 32'h0,         0,  32'h0000_003C, 1'b0};
        tbl[5] = '{1'b0, 4'h4, 32'h0,         0,  32'h0000_0014, 1'b0};
        tbl[6] = '{1'b0, 4'hC, 32'h0,         0,  32'h0000_0000, 1'b1};
        tbl[7] = '{1'b0, 4'h4, 32'h0,         0,  32'h0000_0014, 1'b0};
        tbl[8] = '{1'b0, 4'h0, 32'h0,         0,  32'h0000_0001, 1'b0};

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, rd, err);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, rd, err);
        idle(2);

        // Directed table: single byte with EN off then on, empty read
        fixed_slave = 1'b1;
        next_slave  = 8'h3C;
        seen_q.delete();
        for (int i = 0; i < 9; i++) begin
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, err);
            chk($sformatf("tbl%0d.rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d.err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
            idle(tbl[i].idle_n);
        end
        chk("s1.nstart", 32'(seen_q.size()), 32'd1);
        chk("s1.data", {24'd0, spi_dout}, 32'h0000_00A5);
        fixed_slave = 1'b0;

        // Back-to-back bytes go out in order, one transaction at a time
        seen_q.delete();
        for (int i = 1; i <= 4; i++) apb(1'b1, 4'h8, 32'(i), rd, err);
        idle(60);
        chk("s2.nstart", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < seen_q.size() && i < 4; i++)
            chk($sformatf("s2.order%0d", i), {24'd0, seen_q[i]}, 32'(i + 1));
        for (int i = 0; i < 4; i++) apb(1'b0, 4'hC, 32'd0, rd, err);

        // Stalled driver: fifth queued write overflows TX
        force_busy = 1'b1;
        apb(1'b1, 4'h8, 32'h11, rd, err);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            apb(1'b1, 4'h8, 32'(8'h12 + i), rd, err);
            chk($sformatf("s3.err%0d", i), {31'd0, err}, (i == 4) ? 32'd1 : 32'd0);
        end
        apb(1'b0, 4'h4, 32'd0, rd, err);
        chk("s3.status", rd, 32'h0000_0413);
        force_busy = 1'b0;
        idle(80);

        // RX full stalls a pending byte until one RX read frees a slot
        apb(1'b1, 4'h0, 32'h3, rd, err);
        apb(1'b1, 4'h8, 32'h55, rd, err);
        idle(5);
        apb(1'b0, 4'h4, 32'd0, rd, err);
        chk("s4.status", rd, 32'h0000_4108);
        seen_q.delete();
        apb(1'b0, 4'hC, 32'd0, rd, err);
        idle(2);
        chk("s4.nstart", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0) chk("s4.data", {24'd0, seen_q[0]}, 32'h0000_0055);
        idle(20);
        apb(1'b1, 4'h0, 32'h4, rd, err);
        apb(1'b0, 4'h4, 32'd0, rd, err);
        chk("s4.flushed", rd, 32'h0000_0014);

        // Reset while waiting for busy to fall
        apb(1'b1, 4'h0, 32'h9, rd, err);
        force_busy = 1'b1;
        apb(1'b1, 4'h8, 32'h77, rd, err);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, rd, err);
        chk("s6.irq", {31'd0, irq}, 32'd0);
        apb(1'b0, 4'h4, 32'd0, rd, err);
        chk("s6.status", rd, 32'h0000_0014);
        apb(1'b0, 4'h0, 32'd0, rd, err);
        chk("s6.ctrl", rd, 32'd0);
        force_busy = 1'b0;
        idle(5);
        apb(1'b0, 4'h4, 32'd0, rd, err);
        chk("s6.no_push", rd, 32'h0000_0014);

        // Randomized traffic against the model
        apb(1'b1, 4'h0, 32'h9, rd, err);
        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 35)
                apb(1'b1, {2'd2, 2'($urandom)}, $urandom, rd, err);
            else if (r < 60)
                apb(1'b0, {2'd3, 2'($urandom)}, 32'd0, rd, err);
            else if (r < 70)
                apb(1'b0, {2'd1, 2'($urandom)}, 32'd0, rd, err);
            else if (r < 78)
                apb(1'b1, 4'h0, {$urandom & 32'hFFFF_FFF0,
                                 1'($urandom),
                                 ($urandom_range(0, 9) == 0),
                                 ($urandom_range(0, 9) == 0),
                                 ($urandom_range(0, 7) != 0)}, rd, err);
            else if (r < 82)
                apb(1'b0, {2'd0, 2'($urandom)}, 32'd0, rd, err);
            else if (r < 86)
                apb(1'($urandom), ($urandom_range(0, 1) == 0) ? 4'h4 : 4'hC, $urandom, rd, err);
            else if (r < 88)
                apb(1'b0, 4'h8, 32'd0, rd, err);
            else
                idle(int'($urandom_range(1, 6)));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
